spi_config_master: RTL
======================

Name: spi_config_master

Overview:
- Host-side SPI master that streams a complete configuration/spike frame into the SNN chip's SPI slave port, one byte at a time from a valid/ready byte source.
- Drives SCLK/MOSI/SS and returns the bytes captured on MISO.
- Used in the FPGA test harness and as the bench driver for chip-level verification.
- Runs in the `system_clock` domain; SCLK is generated by an internal divider.

Parameters:
- CLK_DIV, 4, number of system_clock cycles per SCLK half-period; legal range 1..255.
- FRAME_BYTES, 215, number of bytes sent per frame with SS held low; legal range 1..255.

Ports:
- system_clock  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-low reset (low = reset asserted).
- start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- byte_data  input  8  next byte to transmit, MSB sent first.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  master accepts byte_data this cycle.
- rx_data  output  8  byte captured from MISO during the last transmitted byte.
- rx_valid  output  1  one-cycle pulse; rx_data is updated.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when SS returns high.
- SCLK  output  1  SPI clock, idle low.
- MOSI  output  1  SPI data out.
- SS  output  1  slave select, active low.
- MISO  input  1  SPI data in.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - SS=1, SCLK=0, MOSI=0, byte_ready=0, rx_valid=0, done=0, busy=0, rx_data=0.
  - State=IDLE; all counters cleared.
- SPI mode: CPOL=0, CPHA=0, MSB first.
  - MOSI changes only on the first cycle of an SCLK low phase.
  - MISO is sampled on the system_clock cycle in which SCLK goes 0->1.
- States and transitions:
  - IDLE: if start=1, go to SETUP; SS=0 and busy=1 from the next cycle.
  - SETUP: SS low, SCLK low for CLK_DIV cycles, then go to LOAD.
  - LOAD: byte_ready=1, decoded combinationally from state.
    - On byte_valid=1, latch byte_data into the tx shift register, clear bit_cnt, go to SHIFT.
    - If byte_valid=0, stall indefinitely: SS stays 0, SCLK stays 0, MOSI holds its last value.
  - SHIFT: each bit is CLK_DIV cycles with SCLK=0 (MOSI=tx[7]) followed by CLK_DIV cycles with SCLK=1.
    - On the 0->1 cycle, rx shift register <= {rx[6:0], MISO}.
    - At the end of the high phase, tx <= tx<<1 and bit_cnt++.
    - After bit 7's high phase: rx_data <= rx shift result, rx_valid pulses 1 cycle, byte_cnt++.
    - If byte_cnt==FRAME_BYTES go to TEARDOWN, else go to LOAD.
  - TEARDOWN: SCLK low, MOSI=0 for CLK_DIV cycles, then SS=1, done pulses 1 cycle, busy=0, go to IDLE.
- Timing with no stalls: each byte takes 1 + 16*CLK_DIV cycles (LOAD plus 8 bits).
- Divider counter: 8 bits, counts 0..CLK_DIV-1 then wraps.
- bit_cnt is 3 bits. byte_cnt is 8 bits, cleared in IDLE.
- start while busy is ignored; it is neither queued nor does it restart the frame.
- byte_valid outside LOAD is ignored; byte_ready=0 there.
- Exactly 8*FRAME_BYTES SCLK rising edges per frame. SCLK never toggles while SS=1.
- rx_valid and done never assert in the same cycle.

Test Plan:
- Single frame, CLK_DIV=2, FRAME_BYTES=2, bytes 0xA5 then 0x3C always valid:
  - MOSI at SCLK rises = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - 16 rising edges; SS low 2+2*(1+32)+2 cycles; one done pulse.
- Stall, bytes 0x81 then 0x7E, with byte_valid deasserted 10 cycles before the second byte:
  - SCLK stays low and SS stays low for 10 extra cycles.
  - Bit stream is unchanged; rx_valid fires twice.
- MISO tied to MOSI (loopback), FRAME_BYTES=3, bytes 0x00, 0xFF, 0x96:
  - rx_data sequence equals 0x00, 0xFF, 0x96, each with a one-cycle rx_valid.
- Reset asserted low during bit 4 of byte 1:
  - Immediately SS=1, SCLK=0, busy=0.
  - After release, start launches a fresh frame beginning at byte 0, bit 7.
- start pulsed repeatedly while busy:
  - No change to SCLK/MOSI waveform; exactly one done pulse.
  - Next start after done begins a new frame.
- Defaults (CLK_DIV=4, FRAME_BYTES=215), random bytes:
  - Exactly 1720 SCLK rising edges.
  - A scoreboard-decoded byte stream equals the input bytes.

Source files
------------

// File: rtl/spi_config_master.sv
// rtl/spi_config_master.sv - SPI mode-0 master streaming a fixed-length frame from a byte source
// Ports:
//   system_clock      : single clock for all logic
//   reset             : asynchronous active-low reset
//   start             : one-cycle frame request, honoured only in IDLE
//   byte_data/valid   : next byte to send (MSB first) and its qualifier
//   byte_ready        : byte_data is taken this cycle (high only in LOAD)
//   rx_data/rx_valid  : byte captured on MISO and its one-cycle strobe
//   busy/done         : frame in progress / one-cycle pulse when SS returns high
//   SCLK/MOSI/SS/MISO : SPI pins, CPOL=0 CPHA=0, SS active low
module spi_config_master #(
   parameter int CLK_DIV     = 4,
   parameter int FRAME_BYTES = 215
) (
   input  logic       system_clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       done,
   output logic       SCLK,
   output logic       MOSI,
   output logic       SS,
   input  logic       MISO
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_LOAD,
      S_SHIFT,
      S_TEARDOWN
   } state_t;

   localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [7:0] BYTE_LAST = 8'(FRAME_BYTES - 1);

   state_t     state;
   logic [7:0] div_cnt;
   logic [2:0] bit_cnt;
   logic [7:0] byte_cnt;
   // MOSI itself is the MSB of the transmit shifter; tx_sh holds the bits still to go.
   logic [6:0] tx_sh;
   logic [7:0] rx_sh;
   logic       div_end;

   assign div_end    = (div_cnt == DIV_LAST);
   assign byte_ready = (state == S_LOAD);

   always_ff @(posedge system_clock or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         div_cnt  <= 8'd0;
         bit_cnt  <= 3'd0;
         byte_cnt <= 8'd0;
         tx_sh    <= 7'd0;
         rx_sh    <= 8'd0;
         rx_data  <= 8'd0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         SCLK     <= 1'b0;
         MOSI     <= 1'b0;
         SS       <= 1'b1;
      end else begin
         rx_valid <= 1'b0;
         done     <= 1'b0;

         case (state)
            S_IDLE: begin
               div_cnt  <= 8'd0;
               bit_cnt  <= 3'd0;
               byte_cnt <= 8'd0;
               SCLK     <= 1'b0;
               if (start) begin
                  state <= S_SETUP;
                  SS    <= 1'b0;
                  busy  <= 1'b1;
               end
            end

            // SS setup time before the first SCLK edge.
            S_SETUP: begin
               if (div_end) begin
                  div_cnt <= 8'd0;
                  state   <= S_LOAD;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end

            // Waits here with SCLK low and MOSI held until the source has a byte.
            S_LOAD: begin
               if (byte_valid) begin
                  MOSI    <= byte_data[7];
                  tx_sh   <= byte_data[6:0];
                  bit_cnt <= 3'd0;
                  div_cnt <= 8'd0;
                  state   <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               if (!div_end) begin
                  div_cnt <= div_cnt + 8'd1;
               end else begin
                  div_cnt <= 8'd0;
                  if (!SCLK) begin
                     // Rising edge: capture MISO in the same cycle SCLK goes high.
                     SCLK  <= 1'b1;
                     rx_sh <= {rx_sh[6:0], MISO};
                  end else begin
                     // Falling edge: next bit goes out at the start of the low phase.
                     SCLK    <= 1'b0;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt != 3'd7) begin
                        MOSI  <= tx_sh[6];
                        tx_sh <= {tx_sh[5:0], 1'b0};
                     end else begin
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        byte_cnt <= byte_cnt + 8'd1;
                        if (byte_cnt == BYTE_LAST) begin
                           MOSI  <= 1'b0;
                           state <= S_TEARDOWN;
                        end else begin
                           state <= S_LOAD;
                        end
                     end
                  end
               end
            end

            // SS hold time after the last SCLK edge; done lands on the SS rising cycle.
            S_TEARDOWN: begin
               if (div_end) begin
                  div_cnt <= 8'd0;
                  SS      <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end

            default: begin
               state <= S_IDLE;
               SS    <= 1'b1;
               SCLK  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
